// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
package mem_arbiter_pkg;

    localparam int          DEF_MEM_LATENCY     = 4;
    localparam int          DEF_WORDS_PER_BLOCK = 8;
    localparam logic [15:0] BLOCK_MASK          = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FILL_I = 2'd2,
        ST_FILL_D = 2'd3
    } arb_state_e;

    // Byte address of the idx-th 16-bit word of a block.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
        return base + {idx[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Issue and return counters for one block fill, with terminal flags.
module arb_fill_counter
    import mem_arbiter_pkg::*;
#(
    parameter int WORDS = DEF_WORDS_PER_BLOCK,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             issue_inc,
    input  logic             ret_inc,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic             issue_done,
    output logic             ret_last
);

    assign issue_done = (issue_cnt == CNT_W'(WORDS));
    assign ret_last   = (ret_cnt == CNT_W'(WORDS - 1));

    // Count issued reads (saturating at a full block) and accepted returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (clr) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (issue_inc && !issue_done) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (ret_inc) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D-cache block fills and D-cache write-through stores onto one memory port.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate simultaneous fill requests instead of favouring D.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss_req,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss_req,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        i_busy,
    output logic        d_busy,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        d_wr_ack,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid
);

    // Wide enough to span a whole fill window (issue phase plus latency tail).
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK + MEM_LATENCY + 1);

    arb_state_e       state_r;
    arb_state_e       state_s;
    logic [15:0]      base_r;
    logic             i_busy_r;
    logic             d_busy_r;
    logic             grant_d_s;
    logic             fill_i_s;
    logic             fill_d_s;
    logic             in_fill_s;
    logic             issue_s;
    logic             ret_acc_s;
    logic             done_s;
    logic [CNT_W-1:0] issue_cnt_s;
    logic [CNT_W-1:0] ret_cnt_s;
    logic             issue_done_s;
    logic             ret_last_s;

    assign fill_i_s  = (state_r == ST_FILL_I);
    assign fill_d_s  = (state_r == ST_FILL_D);
    assign in_fill_s = fill_i_s | fill_d_s;
    assign issue_s   = in_fill_s & ~issue_done_s;
    assign ret_acc_s = in_fill_s & mem_data_valid;
    assign done_s    = ret_acc_s & ret_last_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_d_r;

    // Select the D cache when it requests alone or when it holds the turn.
    always_comb begin
        grant_d_s = d_miss_req & (~i_miss_req | rr_d_r);
    end

    // Turn pointer flips after every completed fill; starts at the D cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_d_r <= 1'b1;
        end else if (done_s) begin
            rr_d_r <= ~rr_d_r;
        end else begin
            rr_d_r <= rr_d_r;
        end
    end
`else
    // The D cache wins every fill contest.
    always_comb begin
        grant_d_s = d_miss_req;
    end
`endif

    arb_fill_counter #(
        .WORDS (WORDS_PER_BLOCK),
        .CNT_W (CNT_W)
    ) u_fill_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (done_s),
        .issue_inc  (issue_s),
        .ret_inc    (ret_acc_s),
        .issue_cnt  (issue_cnt_s),
        .ret_cnt    (ret_cnt_s),
        .issue_done (issue_done_s),
        .ret_last   (ret_last_s)
    );

    // Next-state selection: stores beat fills, a fill ends on its last return.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_wr_req) begin
                    state_s = ST_WRITE;
                end else if (d_miss_req || i_miss_req) begin
                    state_s = grant_d_s ? ST_FILL_D : ST_FILL_I;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: state_s = ST_IDLE;
            ST_FILL_I, ST_FILL_D: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, block base and stall flags. A waiting cache stays stalled while the other is served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            base_r   <= 16'h0000;
            i_busy_r <= 1'b0;
            d_busy_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            i_busy_r <= (state_s == ST_FILL_I) | (i_miss_req & ((state_s != ST_IDLE) | fill_d_s));
            d_busy_r <= (state_s == ST_FILL_D) | (d_miss_req & ((state_s != ST_IDLE) | fill_i_s));
            if (state_r == ST_IDLE) begin
                base_r <= (grant_d_s ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
            end else begin
                base_r <= base_r;
            end
        end
    end

    // Memory command and fill return buses; all idle values are zero.
    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        d_wr_ack     = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        fill_addr    = 16'h0000;
        fill_data    = 16'h0000;
        if (state_r == ST_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_ack  = 1'b1;
        end else if (issue_s) begin
            mem_en   = 1'b1;
            mem_addr = word_addr(base_r, 16'(issue_cnt_s));
        end else begin
            mem_en = 1'b0;
        end
        if (ret_acc_s) begin
            i_fill_valid = fill_i_s;
            d_fill_valid = fill_d_s;
            i_fill_done  = fill_i_s & done_s;
            d_fill_done  = fill_d_s & done_s;
            fill_addr    = word_addr(base_r, 16'(ret_cnt_s));
            fill_data    = mem_rdata;
        end else begin
            fill_addr = 16'h0000;
        end
    end

    assign i_busy = i_busy_r;
    assign d_busy = d_busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int L = 4;
    localparam int W = 8;
    localparam int M_IDLE = 0, M_WRITE = 1, M_FILL_I = 2, M_FILL_D = 3;

    logic clk = 1'b0;
    logic rst;
    logic i_miss_req, d_miss_req, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic i_busy, d_busy, i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack;
    logic [15:0] fill_addr, fill_data, mem_addr, mem_wdata, mem_rdata;
    logic mem_en, mem_wr, mem_data_valid;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(L), .WORDS_PER_BLOCK(W)) dut (
        .clk(clk), .rst(rst),
        .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
        .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .i_busy(i_busy), .d_busy(d_busy),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_ack(d_wr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit spur_en = 1'b0;
    logic [15:0] key;

    // reference model: who is being served and how far the fill has progressed
    int m_mode, m_iss, m_ret;
    logic [15:0] m_base;
    bit m_rr_d, m_ibusy, m_dbusy;

    // memory model: pending read returns
    int mq_due[$];
    logic [15:0] mq_addr[$];

    // DUT outputs observed in the most recent cycle
    int ob_cyc;
    logic ob_i_busy, ob_d_busy, ob_iv, ob_dv, ob_idone, ob_ddone, ob_ack, ob_en, ob_wr;
    logic [15:0] ob_maddr, ob_mwdata, ob_faddr, ob_fdata;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_iss = 0; m_ret = 0; m_base = 16'h0000;
        m_rr_d = 1'b1; m_ibusy = 1'b0; m_dbusy = 1'b0;
    endtask

    task automatic compare_outputs();
        logic e_en, e_wr, e_ack, e_iv, e_dv, e_id, e_dd;
        logic [15:0] e_ma, e_mw, e_fa, e_fd;
        e_en = 1'b0; e_wr = 1'b0; e_ack = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_id = 1'b0; e_dd = 1'b0;
        e_ma = 16'h0000; e_mw = 16'h0000; e_fa = 16'h0000; e_fd = 16'h0000;
        if (m_mode == M_WRITE) begin
            e_en = 1'b1; e_wr = 1'b1; e_ack = 1'b1; e_ma = d_wr_addr; e_mw = d_wr_data;
        end else if (m_mode == M_FILL_I || m_mode == M_FILL_D) begin
            if (m_iss < W) begin
                e_en = 1'b1;
                e_ma = m_base + 16'(2 * m_iss);
            end
            if (mem_data_valid === 1'b1 && m_ret < W) begin
                e_fa = m_base + 16'(2 * m_ret);
                e_fd = mem_rdata;
                e_iv = (m_mode == M_FILL_I);
                e_dv = (m_mode == M_FILL_D);
                e_id = e_iv && (m_ret == W - 1);
                e_dd = e_dv && (m_ret == W - 1);
            end
        end
        chk("i_busy", 16'(i_busy), 16'(m_ibusy));
        chk("d_busy", 16'(d_busy), 16'(m_dbusy));
        chk("mem_en", 16'(mem_en), 16'(e_en));
        chk("mem_wr", 16'(mem_wr), 16'(e_wr));
        chk("mem_addr", mem_addr, e_ma);
        chk("mem_wdata", mem_wdata, e_mw);
        chk("d_wr_ack", 16'(d_wr_ack), 16'(e_ack));
        chk("i_fill_valid", 16'(i_fill_valid), 16'(e_iv));
        chk("d_fill_valid", 16'(d_fill_valid), 16'(e_dv));
        chk("fill_addr", fill_addr, e_fa);
        chk("fill_data", fill_data, e_fd);
        chk("i_fill_done", 16'(i_fill_done), 16'(e_id));
        chk("d_fill_done", 16'(d_fill_done), 16'(e_dd));
        ob_cyc = cyc;
        ob_i_busy = i_busy; ob_d_busy = d_busy; ob_iv = i_fill_valid; ob_dv = d_fill_valid;
        ob_idone = i_fill_done; ob_ddone = d_fill_done; ob_ack = d_wr_ack; ob_en = mem_en; ob_wr = mem_wr;
        ob_maddr = mem_addr; ob_mwdata = mem_wdata; ob_faddr = fill_addr; ob_fdata = fill_data;
    endtask

    // Advance the model by one clock using the inputs held during the cycle.
    task automatic model_step();
        int nxt;
        bit fin;
        if (rst) begin
            model_reset();
            return;
        end
        nxt = m_mode;
        fin = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (d_wr_req) nxt = M_WRITE;
                else if (i_miss_req && d_miss_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    nxt = m_rr_d ? M_FILL_D : M_FILL_I;
`else
                    nxt = M_FILL_D;
`endif
                end
                else if (d_miss_req) nxt = M_FILL_D;
                else if (i_miss_req) nxt = M_FILL_I;
                if (nxt == M_FILL_D) m_base = d_miss_addr & 16'hFFF0;
                if (nxt == M_FILL_I) m_base = i_miss_addr & 16'hFFF0;
            end
            M_WRITE: nxt = M_IDLE;
            default: begin
                if (m_iss < W) m_iss++;
                if (mem_data_valid && m_ret < W) begin
                    m_ret++;
                    if (m_ret == W) begin
                        fin = 1'b1;
                        nxt = M_IDLE;
                    end
                end
            end
        endcase
        if (fin) begin
            m_iss = 0; m_ret = 0; m_rr_d = !m_rr_d;
        end
        m_ibusy = (nxt == M_FILL_I) || (i_miss_req && (nxt != M_IDLE || m_mode == M_FILL_D));
        m_dbusy = (nxt == M_FILL_D) || (d_miss_req && (nxt != M_IDLE || m_mode == M_FILL_I));
        m_mode = nxt;
    endtask

    task automatic step_cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        if (ob_en && !ob_wr) begin
            mq_due.push_back(cyc + L);
            mq_addr.push_back(ob_maddr);
        end
        cyc++;
        model_step();
        #1;
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            mem_data_valid = 1'b1;
            mem_rdata = mq_addr[0] ^ key;
            void'(mq_due.pop_front());
            void'(mq_addr.pop_front());
        end else begin
            mem_data_valid = spur_en && (m_mode == M_IDLE || m_mode == M_WRITE) && ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step_cycle();
        step_cycle();
        rst = 1'b0;
    endtask

    int first, done_c, nissue, nval, ndone, dcount, ack_c, rd_c;
    logic [15:0] iss_a[W];
    logic [1:0] ord[3];
    logic [1:0] e_ord[3];
    logic [15:0] ack_addr, ack_data;
    logic ack_wr;

    initial begin
        rst = 1'b1;
        i_miss_req = 1'b0; d_miss_req = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = 16'h0000; d_miss_addr = 16'h0000; d_wr_addr = 16'h0000; d_wr_data = 16'h0000;
        mem_rdata = 16'h0000; mem_data_valid = 1'b0;
        key = 16'($urandom);
        model_reset();
        step_cycle();
        step_cycle();
        chk("reset_ctrl", 16'({ob_i_busy, ob_d_busy, ob_iv, ob_dv, ob_idone, ob_ddone, ob_ack, ob_en, ob_wr}), 16'h0000);
        chk("reset_buses", ob_maddr | ob_mwdata | ob_faddr | ob_fdata, 16'h0000);
        rst = 1'b0;
        step_cycle();

        // single I-cache fill of the block holding 16'h1234
        i_miss_addr = 16'h1234; i_miss_req = 1'b1;
        first = -1; done_c = -1; nissue = 0; nval = 0;
        for (int t = 0; t < 40 && done_c < 0; t++) begin
            step_cycle();
            if (ob_en && !ob_wr) begin
                if (nissue < W) iss_a[nissue] = ob_maddr;
                if (first < 0) first = ob_cyc;
                nissue++;
            end
            if (ob_iv) nval++;
            if (ob_idone) begin done_c = ob_cyc; i_miss_req = 1'b0; end
        end
        for (int k = 0; k < W; k++) chk("blk_issue_addr", iss_a[k], 16'h1230 + 16'(2 * k));
        chk("blk_issue_count", 16'(nissue), 16'd8);
        chk("blk_valid_count", 16'(nval), 16'd8);
        // occupancy counted inclusively: first-issue cycle through done cycle
        chk("blk_occupancy", 16'(done_c - first + 1), 16'd12);
        repeat (3) step_cycle();

        // simultaneous misses; D re-requests the moment its first fill ends
        do_reset();
        i_miss_addr = 16'h2000; d_miss_addr = 16'h3000; i_miss_req = 1'b1; d_miss_req = 1'b1;
        ndone = 0; dcount = 0;
        ord[0] = 2'd0; ord[1] = 2'd0; ord[2] = 2'd0;
        for (int t = 0; t < 120 && ndone < 3; t++) begin
            step_cycle();
            if (ob_ddone) begin
                ord[ndone] = 2'd2; ndone++; dcount++;
                if (dcount == 1) d_miss_addr = 16'h3100;
                else d_miss_req = 1'b0;
            end
            if (ob_idone && ndone < 3) begin
                ord[ndone] = 2'd1; ndone++; i_miss_req = 1'b0;
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        e_ord[0] = 2'd2; e_ord[1] = 2'd1; e_ord[2] = 2'd2;
`else
        e_ord[0] = 2'd2; e_ord[1] = 2'd2; e_ord[2] = 2'd1;
`endif
        for (int k = 0; k < 3; k++) chk("pair_order", 16'(ord[k]), 16'(e_ord[k]));
        i_miss_req = 1'b0; d_miss_req = 1'b0;
        repeat (3) step_cycle();

        // store arriving mid-fill waits for the fill to finish
        i_miss_addr = 16'h5678; i_miss_req = 1'b1;
        for (int t = 0; t < 10 && !(ob_en && !ob_wr); t++) step_cycle();
        d_wr_addr = 16'h0400; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
        done_c = -100; ack_c = -1; ack_addr = 16'h0000; ack_data = 16'h0000; ack_wr = 1'b0;
        for (int t = 0; t < 60 && ack_c < 0; t++) begin
            step_cycle();
            if (ob_idone) begin done_c = ob_cyc; i_miss_req = 1'b0; end
            if (ob_ack) begin
                ack_c = ob_cyc; ack_addr = ob_maddr; ack_data = ob_mwdata; ack_wr = ob_wr;
                d_wr_req = 1'b0;
            end
        end
        chk("store_after_fill", 16'(ack_c - done_c), 16'd2);
        chk("store_addr", ack_addr, 16'h0400);
        chk("store_data", ack_data, 16'hBEEF);
        chk("store_wr", 16'(ack_wr), 16'd1);
        repeat (3) step_cycle();

        // reset after three returns of a D fill
        d_miss_addr = 16'h7000; d_miss_req = 1'b1; nval = 0;
        for (int t = 0; t < 40 && nval < 3; t++) begin
            step_cycle();
            if (ob_dv) nval++;
        end
        rst = 1'b1; model_reset(); d_miss_req = 1'b0;
        step_cycle();
        chk("rst_ctrl", 16'({ob_i_busy, ob_d_busy, ob_iv, ob_dv, ob_idone, ob_ddone, ob_ack, ob_en, ob_wr}), 16'h0000);
        chk("rst_buses", ob_maddr | ob_mwdata | ob_faddr | ob_fdata, 16'h0000);
        step_cycle();
        rst = 1'b0;
        nval = 0;
        for (int t = 0; t < 10; t++) begin
            step_cycle();
            if (ob_dv || ob_iv || ob_en) nval++;
        end
        chk("rst_late_ignored", 16'(nval), 16'd0);
        d_miss_req = 1'b1; nval = 0; done_c = -1;
        for (int t = 0; t < 40 && done_c < 0; t++) begin
            step_cycle();
            if (ob_dv) nval++;
            if (ob_ddone) begin done_c = ob_cyc; d_miss_req = 1'b0; end
        end
        chk("refill_valid_count", 16'(nval), 16'd8);
        repeat (3) step_cycle();

        // store and D miss together: WRITE, back to IDLE, then the D fill
        d_wr_addr = 16'h0800; d_wr_data = 16'h1111; d_wr_req = 1'b1;
        d_miss_addr = 16'h9000; d_miss_req = 1'b1;
        ack_c = -1; rd_c = -1; done_c = -1;
        for (int t = 0; t < 40 && done_c < 0; t++) begin
            step_cycle();
            if (ob_ack) begin ack_c = ob_cyc; d_wr_req = 1'b0; end
            if (ob_en && !ob_wr && rd_c < 0) rd_c = ob_cyc;
            if (ob_ddone) begin done_c = ob_cyc; d_miss_req = 1'b0; end
        end
        chk("wr_then_fill_gap", 16'(rd_c - ack_c), 16'd2);
        chk("wr_then_fill_done", 16'(done_c >= 0), 16'd1);
        repeat (3) step_cycle();

        // randomised traffic with spurious returns and occasional reset
        spur_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            step_cycle();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) begin rst = 1'b1; model_reset(); end
            if (ob_idone) i_miss_req = 1'b0;
            else if (!i_miss_req && $urandom_range(0, 7) == 0) begin i_miss_req = 1'b1; i_miss_addr = 16'($urandom); end
            else if (i_miss_req && $urandom_range(0, 63) == 0) i_miss_req = 1'b0;
            if ($urandom_range(0, 15) == 0) i_miss_addr = 16'($urandom);
            if (ob_ddone) d_miss_req = 1'b0;
            else if (!d_miss_req && $urandom_range(0, 7) == 0) begin d_miss_req = 1'b1; d_miss_addr = 16'($urandom); end
            else if (d_miss_req && $urandom_range(0, 63) == 0) d_miss_req = 1'b0;
            if ($urandom_range(0, 15) == 0) d_miss_addr = 16'($urandom);
            if (ob_ack) d_wr_req = 1'b0;
            else if (!d_wr_req && $urandom_range(0, 9) == 0) begin
                d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
